// File: rtl/adc_acq_ctrl.sv
// Serial-ADC acquisition sequencer: CNV strobe, SCK burst with sample strobes, TLU busy, frame/loss counters.
// Define TLU_TRIG_EN to take trigger events from trig_in rising edges instead of the free-run period timer.
module adc_acq_ctrl #(
  parameter int CONV_CYC     = 60,
  parameter int CNV_HIGH_CYC = 4,
  parameter int NBITS        = 16,
  parameter int DEAD_CYC     = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             trig_in,
  input  logic [15:0]      period,
  output logic             cnv,
  output logic             sck,
  output logic             sample_stb,
  output logic             frame_done,
  output logic             busy,
  output logic             trig_lost,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CONV  = 3'd2,
    SHIFT = 3'd3,
    DEAD  = 3'd4
  } state_t;

  localparam int SHIFT_CYC = 2 * NBITS;
  localparam int MAX_CYC   = (CONV_CYC > SHIFT_CYC)
                             ? ((CONV_CYC > DEAD_CYC) ? CONV_CYC : DEAD_CYC)
                             : ((SHIFT_CYC > DEAD_CYC) ? SHIFT_CYC : DEAD_CYC);
  localparam int CYC_W     = $clog2(MAX_CYC + 1);

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic             last_cyc;
  logic             trig_ev;
  logic             stop_pend;

`ifdef TLU_TRIG_EN
  logic trig_prev;
  logic unused_period;

  assign unused_period = ^period;
  assign trig_ev       = (state != IDLE) && trig_in && !trig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_prev <= 1'b0;
    else        trig_prev <= trig_in;
  end
`else
  logic [15:0] pcnt;
  logic [15:0] pterm;
  logic        unused_trig;

  // Periods below 2 are clamped so an event can never fire every cycle.
  assign pterm       = (period < 16'd2) ? 16'd1 : period - 16'd1;
  assign trig_ev     = (state != IDLE) && (pcnt == pterm);
  assign unused_trig = trig_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          pcnt <= 16'd0;
    else if (state == IDLE || trig_ev)   pcnt <= 16'd0;
    else                                 pcnt <= pcnt + 16'd1;
  end
`endif

  always_comb begin
    last_cyc = 1'b0;
    case (state)
      CONV:    last_cyc = (cyc == CYC_W'(CONV_CYC - 1));
      SHIFT:   last_cyc = (cyc == CYC_W'(SHIFT_CYC - 1));
      DEAD:    last_cyc = (cyc == CYC_W'(DEAD_CYC - 1));
      default: last_cyc = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED: begin
        if (stop)         state_nxt = IDLE;
        else if (trig_ev) state_nxt = CONV;
      end
      CONV:    if (last_cyc) state_nxt = SHIFT;
      SHIFT:   if (last_cyc) state_nxt = DEAD;
      DEAD:    if (last_cyc) state_nxt = (stop_pend || stop) ? IDLE : ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      stop_pend  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      trig_lost  <= 1'b0;
      frame_cnt  <= '0;
      lost_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cyc        <= (state_nxt != state) ? '0 : cyc + CYC_W'(1);
      busy       <= (state_nxt == CONV) || (state_nxt == SHIFT) || (state_nxt == DEAD);
      frame_done <= (state == SHIFT) && last_cyc;
      trig_lost  <= trig_ev && busy;
      if (state_nxt == IDLE)
        stop_pend <= 1'b0;
      else if (stop && (state == CONV || state == SHIFT || state == DEAD))
        stop_pend <= 1'b1;
      if (state == SHIFT && last_cyc)
        frame_cnt <= frame_cnt + CNT_W'(1);
      // Loss counter saturates rather than wrapping.
      if (trig_ev && busy && lost_cnt != '1)
        lost_cnt <= lost_cnt + CNT_W'(1);
    end
  end

  // Strobes decode straight from state so reset forces them low immediately.
  assign cnv        = (state == CONV) && (cyc < CYC_W'(CNV_HIGH_CYC));
  assign sck        = (state == SHIFT) && !cyc[0];
  assign sample_stb = (state == SHIFT) && cyc[0];
  assign state_o    = state;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed self-checking bench for adc_acq_ctrl; a second instance with CNT_W=4 exercises counter wrap/saturation.
module tb_adc_acq_ctrl;

  logic        clk, rst_n, rst4_n, start, stop, trig_in;
  logic [15:0] period;
  logic        cnv, sck, sample_stb, frame_done, busy, trig_lost;
  logic [15:0] frame_cnt, lost_cnt;
  logic [2:0]  state_o;
  logic        cnv4, sck4, stb4, done4, busy4, lost4;
  logic [3:0]  frame_cnt4, lost_cnt4;
  logic [2:0]  state4;

  int n_vec = 0, n_err = 0;
  int idx, n_cnv_rise, first_cnv, n_cnv_hi, n_stb, n_sck, n_done, first_done, n_lost, n_busy, first_busy;
  logic prev_cnv;

  adc_acq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .trig_in(trig_in), .period(period),
    .cnv(cnv), .sck(sck), .sample_stb(sample_stb), .frame_done(frame_done), .busy(busy),
    .trig_lost(trig_lost), .frame_cnt(frame_cnt), .lost_cnt(lost_cnt), .state_o(state_o)
  );

  adc_acq_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start), .stop(stop), .trig_in(trig_in), .period(period),
    .cnv(cnv4), .sck(sck4), .sample_stb(stb4), .frame_done(done4), .busy(busy4),
    .trig_lost(lost4), .frame_cnt(frame_cnt4), .lost_cnt(lost_cnt4), .state_o(state4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_stats();
    idx = 0; n_cnv_rise = 0; first_cnv = -1; n_cnv_hi = 0; n_stb = 0; n_sck = 0;
    n_done = 0; first_done = -1; n_lost = 0; n_busy = 0; first_busy = -1; prev_cnv = 1'b0;
  endtask

  // Samples the current negedge, then advances to the next one.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (cnv && !prev_cnv) begin
        n_cnv_rise++;
        if (first_cnv < 0) first_cnv = idx;
      end
      if (cnv) n_cnv_hi++;
      if (sample_stb) n_stb++;
      if (sck) n_sck++;
      if (frame_done) begin
        n_done++;
        if (first_done < 0) first_done = idx;
      end
      if (trig_lost) n_lost++;
      if (busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = idx;
      end
      prev_cnv = cnv;
      @(negedge clk);
      idx++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({cnv, sck, sample_stb, frame_done, busy, trig_lost} !== 6'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 000000", {cnv, sck, sample_stb, frame_done, busy, trig_lost});
    end
    n_vec++;
    if ({frame_cnt, lost_cnt, state_o} !== 35'd0) begin
      n_err++; $display("FAIL reset_counters: got fc=%0d lc=%0d st=%0d want 0 0 0", frame_cnt, lost_cnt, state_o);
    end
  endtask

  task automatic test_arm_disarm();
    do_reset();
    period = 16'd1000;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL stop_in_idle: got %0d want 0", state_o); end
    arm();
    n_vec++;
    if (state_o !== 3'd1) begin n_err++; $display("FAIL arm_state: got %0d want 1", state_o); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_vec++;
    if ({state_o, busy} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL start_in_armed: got st=%0d busy=%0d want 1 0", state_o, busy); end
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL stop_in_armed: got %0d want 0", state_o); end
    // Stop and a trigger event in the same ARMED cycle: stop wins.
    period = 16'd2;
    arm();
    @(negedge clk);
    stop = 1'b1;
`ifdef TLU_TRIG_EN
    trig_in = 1'b1;
`endif
    @(negedge clk);
    stop = 1'b0; trig_in = 1'b0;
    n_vec++;
    if ({state_o, busy, lost_cnt} !== {3'd0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL stop_priority: got st=%0d busy=%0d lc=%0d want 0 0 0", state_o, busy, lost_cnt);
    end
  endtask

`ifdef TLU_TRIG_EN
  task automatic test_tlu_trigger();
    do_reset();
    period = 16'd5;
    arm();
    run_cycles(5);  trig_in = 1'b1;
    run_cycles(15); trig_in = 1'b0;
    run_cycles(15); trig_in = 1'b1;
    run_cycles(165); trig_in = 1'b0;
    n_vec++;
    if (first_busy !== 6) begin n_err++; $display("FAIL tlu_busy_rise: got %0d want 6", first_busy); end
    n_vec++;
    if (n_busy !== 100) begin n_err++; $display("FAIL tlu_busy_len: got %0d want 100", n_busy); end
    n_vec++;
    if ({n_lost, int'(lost_cnt)} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL tlu_lost: got pulses=%0d lc=%0d want 1 1", n_lost, lost_cnt); end
    n_vec++;
    if ({n_stb, int'(frame_cnt), first_done} !== {32'd16, 32'd1, 32'd98}) begin
      n_err++; $display("FAIL tlu_frame: got stb=%0d fc=%0d done@%0d want 16 1 98", n_stb, frame_cnt, first_done);
    end
  endtask
`else
  task automatic test_free_run();
    do_reset();
    period = 16'd200;
    arm();
    run_cycles(700);
    n_vec++;
    if (first_cnv !== 200) begin n_err++; $display("FAIL fr_first_cnv: got %0d want 200", first_cnv); end
    n_vec++;
    if ({n_cnv_rise, n_cnv_hi} !== {32'd3, 32'd12}) begin n_err++; $display("FAIL fr_cnv: got rises=%0d hi=%0d want 3 12", n_cnv_rise, n_cnv_hi); end
    n_vec++;
    if ({n_stb, n_sck} !== {32'd48, 32'd48}) begin n_err++; $display("FAIL fr_bits: got stb=%0d sck=%0d want 48 48", n_stb, n_sck); end
    n_vec++;
    if ({first_done, n_done} !== {32'd292, 32'd3}) begin n_err++; $display("FAIL fr_done: got @%0d n=%0d want 292 3", first_done, n_done); end
    n_vec++;
    if ({first_busy, n_busy} !== {32'd200, 32'd300}) begin n_err++; $display("FAIL fr_busy: got @%0d n=%0d want 200 300", first_busy, n_busy); end
    n_vec++;
    if ({frame_cnt, lost_cnt, 16'(n_lost)} !== {16'd3, 16'd0, 16'd0}) begin
      n_err++; $display("FAIL fr_counts: got fc=%0d lc=%0d lost=%0d want 3 0 0", frame_cnt, lost_cnt, n_lost);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    period = 16'd60;
    arm();
    run_cycles(590);
    n_vec++;
    if ({n_cnv_rise, n_done, n_lost} !== {32'd5, 32'd4, 32'd4}) begin
      n_err++; $display("FAIL ovr_pulses: got cnv=%0d done=%0d lost=%0d want 5 4 4", n_cnv_rise, n_done, n_lost);
    end
    n_vec++;
    if ({frame_cnt, lost_cnt} !== {16'd4, 16'd4}) begin n_err++; $display("FAIL ovr_counts: got fc=%0d lc=%0d want 4 4", frame_cnt, lost_cnt); end
  endtask

  task automatic test_stop_in_shift();
    do_reset();
    period = 16'd300;
    arm();
    run_cycles(370);
    stop = 1'b1; run_cycles(1); stop = 1'b0;
    run_cycles(28);
    n_vec++;
    if ({state_o, busy} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL stop_dead: got st=%0d busy=%0d want 4 1", state_o, busy); end
    run_cycles(1);
    n_vec++;
    if ({state_o, busy} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL stop_idle: got st=%0d busy=%0d want 0 0", state_o, busy); end
    run_cycles(300);
    n_vec++;
    if ({n_stb, n_done, n_cnv_rise} !== {32'd16, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL stop_frame: got stb=%0d done=%0d cnv=%0d want 16 1 1", n_stb, n_done, n_cnv_rise);
    end
    n_vec++;
    if ({frame_cnt, lost_cnt, state_o} !== {16'd1, 16'd0, 3'd0}) begin
      n_err++; $display("FAIL stop_after: got fc=%0d lc=%0d st=%0d want 1 0 0", frame_cnt, lost_cnt, state_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    period = 16'd60;
    arm();
    run_cycles(181);
    n_vec++;
    if ({cnv, frame_cnt, lost_cnt} !== {1'b1, 16'd1, 16'd1}) begin
      n_err++; $display("FAIL pre_reset: got cnv=%0d fc=%0d lc=%0d want 1 1 1", cnv, frame_cnt, lost_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cnv, sck, busy, sample_stb, state_o} !== 7'd0) begin
      n_err++; $display("FAIL async_reset_outs: got cnv=%0d sck=%0d busy=%0d stb=%0d st=%0d want 0", cnv, sck, busy, sample_stb, state_o);
    end
    n_vec++;
    if ({frame_cnt, lost_cnt} !== 32'd0) begin n_err++; $display("FAIL async_reset_cnt: got fc=%0d lc=%0d want 0 0", frame_cnt, lost_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    run_cycles(200);
    n_vec++;
    if ({n_done, n_busy, int'(state_o)} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL post_reset_idle: got done=%0d busy=%0d st=%0d want 0 0 0", n_done, n_busy, state_o);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    rst4_n = 1'b1;
    period = 16'd60;
    arm();
    run_cycles(2000);
    n_vec++;
    if ({frame_cnt4, lost_cnt4} !== {4'd0, 4'd15}) begin n_err++; $display("FAIL wrap16: got fc=%0d lc=%0d want 0 15", frame_cnt4, lost_cnt4); end
    n_vec++;
    if ({frame_cnt, lost_cnt} !== {16'd16, 16'd16}) begin n_err++; $display("FAIL wide16: got fc=%0d lc=%0d want 16 16", frame_cnt, lost_cnt); end
    run_cycles(100);
    n_vec++;
    if ({frame_cnt4, lost_cnt4} !== {4'd1, 4'd15}) begin n_err++; $display("FAIL wrap17: got fc=%0d lc=%0d want 1 15", frame_cnt4, lost_cnt4); end
    n_vec++;
    if ({frame_cnt, lost_cnt} !== {16'd17, 16'd17}) begin n_err++; $display("FAIL wide17: got fc=%0d lc=%0d want 17 17", frame_cnt, lost_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; start = 1'b0; stop = 1'b0; trig_in = 1'b0; period = 16'd0;
    clear_stats();
    test_reset();
    test_arm_disarm();
`ifdef TLU_TRIG_EN
    test_tlu_trigger();
`else
    test_free_run();
    test_overrun();
    test_stop_in_shift();
    test_reset_mid_frame();
    test_counter_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
